// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the GPU memory arbiters.
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } arb_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_pick
    import gpu_mem_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IB = idx_bits(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IB-1:0] ptr_i,
    output logic          grant_valid_o,
    output logic [IB-1:0] grant_idx_o
);

    logic [N-1:0] rot;
    logic [IB:0]  sum;

    // Rotate so bit 0 is the pointer position, then take the lowest set offset.
    always_comb begin
        rot           = N'({req_i, req_i} >> ptr_i);
        grant_valid_o = |rot;
        grant_idx_o   = '0;
        sum           = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr_i} + (IB + 1)'(k);
                if (sum >= (IB + 1)'(N)) sum = sum - (IB + 1)'(N);
                grant_idx_o = sum[IB-1:0];
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel between LSU requesters.
module data_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int READ_NUM      = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]        consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS*READ_NUM*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]        consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]        consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
    output logic                                      mem_read_valid,
    output logic [ADDR_BITS-1:0]                      mem_read_address,
    input  logic                                      mem_read_ready,
    input  logic [READ_NUM*DATA_BITS-1:0]             mem_read_data,
    output logic                                      mem_write_valid,
    output logic [ADDR_BITS-1:0]                      mem_write_address,
    output logic [DATA_BITS-1:0]                      mem_write_data,
    input  logic                                      mem_write_ready
);

    localparam int IB = idx_bits(NUM_CONSUMERS);
    localparam int RW = READ_NUM * DATA_BITS;

    logic [ADDR_BITS-1:0] rd_addr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] wr_addr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] wr_data [NUM_CONSUMERS];

    arb_state_t               state_q, state_d;
    logic [IB-1:0]            idx_q, idx_d;
    logic [IB-1:0]            ptr_q, ptr_d;
    logic                     is_rd_q, is_rd_d;
    logic                     mrv_q, mrv_d;
    logic                     mwv_q, mwv_d;
    logic [ADDR_BITS-1:0]     mra_q, mra_d;
    logic [ADDR_BITS-1:0]     mwa_q, mwa_d;
    logic [DATA_BITS-1:0]     mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0] crr_q, crr_d;
    logic [NUM_CONSUMERS-1:0] cwr_q, cwr_d;
    logic [RW-1:0]            rdata_q [NUM_CONSUMERS];
    logic [RW-1:0]            rdata_d [NUM_CONSUMERS];

    logic          gnt_valid;
    logic [IB-1:0] gnt_idx;
    logic          relay_done;

    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_slot
        assign rd_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_addr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_data[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[i*RW +: RW] = rdata_q[i];
    end

    rr_pick #(.N(NUM_CONSUMERS)) u_pick (
        .req_i         (consumer_read_valid | consumer_write_valid),
        .ptr_i         (ptr_q),
        .grant_valid_o (gnt_valid),
        .grant_idx_o   (gnt_idx)
    );

    // A completed transaction may only be retired once both the requester and
    // memory have released their handshake, so a lingering mem ready cannot
    // complete the next request.
    assign relay_done = is_rd_q ? (!consumer_read_valid[idx_q]  && !mem_read_ready)
                                : (!consumer_write_valid[idx_q] && !mem_write_ready);

    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign consumer_read_ready  = crr_q;
    assign consumer_write_ready = cwr_q;

    // State and registered-output storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            is_rd_q <= 1'b0;
            mrv_q   <= 1'b0;
            mwv_q   <= 1'b0;
            mra_q   <= '0;
            mwa_q   <= '0;
            mwd_q   <= '0;
            crr_q   <= '0;
            cwr_q   <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) rdata_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            is_rd_q <= is_rd_d;
            mrv_q   <= mrv_d;
            mwv_q   <= mwv_d;
            mra_q   <= mra_d;
            mwa_q   <= mwa_d;
            mwd_q   <= mwd_d;
            crr_q   <= crr_d;
            cwr_q   <= cwr_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (gnt_valid)
                            state_d = consumer_read_valid[gnt_idx] ? READ_WAIT : WRITE_WAIT;
            READ_WAIT:  if (mem_read_ready)  state_d = RELAY;
            WRITE_WAIT: if (mem_write_ready) state_d = RELAY;
            RELAY:      if (relay_done)      state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and grant bookkeeping.
    always_comb begin
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        is_rd_d = is_rd_q;
        mrv_d   = mrv_q;
        mwv_d   = mwv_q;
        mra_d   = mra_q;
        mwa_d   = mwa_q;
        mwd_d   = mwd_q;
        crr_d   = crr_q;
        cwr_d   = cwr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    idx_d = gnt_idx;
                    ptr_d = (gnt_idx == IB'(NUM_CONSUMERS - 1)) ? '0 : gnt_idx + 1'b1;
                    if (consumer_read_valid[gnt_idx]) begin
                        is_rd_d = 1'b1;
                        mrv_d   = 1'b1;
                        mra_d   = rd_addr[gnt_idx];
                    end else begin
                        is_rd_d = 1'b0;
                        mwv_d   = 1'b1;
                        mwa_d   = wr_addr[gnt_idx];
                        mwd_d   = wr_data[gnt_idx];
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mrv_d          = 1'b0;
                    rdata_d[idx_q] = mem_read_data;
                    crr_d[idx_q]   = 1'b1;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mwv_d        = 1'b0;
                    cwr_d[idx_q] = 1'b1;
                end
            end
            RELAY: begin
                if (relay_done) begin
                    crr_d = '0;
                    cwr_d = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: queued requesters, a latency-configurable memory
// and a transaction-level round-robin reference model.
module tb_data_mem_arbiter;

    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 8;
    localparam int RN = 4;
    localparam int RW = RN * DB;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    rv, wv;
    logic [N*AB-1:0] raddr, waddr;
    logic [N*DB-1:0] wdata;
    logic [N-1:0]    consumer_read_ready, consumer_write_ready;
    logic [N*RW-1:0] consumer_read_data;
    logic            mem_read_valid, mem_write_valid;
    logic [AB-1:0]   mem_read_address, mem_write_address;
    logic [DB-1:0]   mem_write_data;
    logic            mrr, mwr;
    logic [RW-1:0]   mrd;

    data_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .READ_NUM(RN)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(raddr),
        .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
        .consumer_write_valid(wv), .consumer_write_address(waddr),
        .consumer_write_data(wdata), .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mwr)
    );

    always #5 clk = ~clk;

    // External memory: ready after mem_lat extra cycles, held hold_extra cycles after valid drops.
    logic [7:0] phys [256];
    int mem_lat = 0, hold_extra = 0;
    int rcnt, rhold, wcnt, whold;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mrr <= 1'b0; mwr <= 1'b0; mrd <= '0;
            rcnt <= 0; rhold <= 0; wcnt <= 0; whold <= 0;
            for (int i = 0; i < 256; i++) phys[i] <= 8'(i + 1);
        end else begin
            if (mem_read_valid) begin
                if (!mrr) begin
                    if (rcnt >= mem_lat) begin
                        mrr <= 1'b1; rcnt <= 0; rhold <= hold_extra;
                        for (int k = 0; k < RN; k++)
                            mrd[k*DB +: DB] <= phys[8'(int'(mem_read_address) + k)];
                    end else rcnt <= rcnt + 1;
                end
            end else if (mrr) begin
                if (rhold > 0) rhold <= rhold - 1; else mrr <= 1'b0;
            end
            if (mem_write_valid) begin
                if (!mwr) begin
                    if (wcnt >= mem_lat) begin
                        mwr <= 1'b1; wcnt <= 0; whold <= hold_extra;
                        phys[mem_write_address] <= mem_write_data;
                    end else wcnt <= wcnt + 1;
                end
            end else if (mwr) begin
                if (whold > 0) whold <= whold - 1; else mwr <= 1'b0;
            end
        end
    end

    // Reference model and requester state.
    int         passed = 0, total = 0;
    int         ptr_m, cur, cyc, last_lat;
    bit         cur_rd;
    logic [7:0] cur_addr, cur_data;
    logic [7:0] mem_m [256];
    logic [RW-1:0] exp_rd [N];
    logic [7:0] rq_a [N][$];
    logic [7:0] wq_a [N][$];
    logic [7:0] wq_d [N][$];
    bit         rd_act [N];
    bit         wr_act [N];
    int         raise_cyc [N];
    int         gseq [$];
    logic       p_mrv, p_mwv, p_mrr, p_mwr;
    logic [N-1:0] p_crr, p_cwr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int winner(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        ptr_m = 0; cur = -1; cur_rd = 0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'(i + 1);
        for (int c = 0; c < N; c++) begin
            exp_rd[c] = '0; rd_act[c] = 0; wr_act[c] = 0;
            rq_a[c].delete(); wq_a[c].delete(); wq_d[c].delete();
        end
        rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
        p_mrv = 0; p_mwv = 0; p_mrr = 0; p_mwr = 0; p_crr = '0; p_cwr = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"}, 64'(|consumer_read_data), 0);
        chk({tag, "_ctl"}, 64'({consumer_read_ready, consumer_write_ready, mem_read_valid,
                                mem_read_address, mem_write_valid, mem_write_address,
                                mem_write_data}), 0);
    endtask

    // One cycle: check outputs against the model, then update requester drive.
    task automatic step();
        int w;
        @(negedge clk);
        cyc++;
        chk("one_mem_valid", 64'(mem_read_valid & mem_write_valid), 0);
        chk("onehot_ready", 64'($countones({consumer_read_ready, consumer_write_ready}) <= 1), 1);
        if ((mem_read_valid || mem_write_valid) && !(p_mrv || p_mwv)) begin
            w = winner(rv | wv);
            chk("grant_exists", 64'(w >= 0), 1);
            chk("no_stale_ready", 64'(p_mrr | p_mwr), 0);
            if (w >= 0) begin
                cur = w; cur_rd = rv[w]; gseq.push_back(w);
                chk("grant_kind", 64'(mem_read_valid), 64'(rv[w]));
                if (rv[w]) begin
                    cur_addr = raddr[w*AB +: AB];
                    chk("rd_addr", 64'(mem_read_address), 64'(cur_addr));
                end else begin
                    cur_addr = waddr[w*AB +: AB];
                    cur_data = wdata[w*DB +: DB];
                    chk("wr_addr", 64'(mem_write_address), 64'(cur_addr));
                    chk("wr_data", 64'(mem_write_data), 64'(cur_data));
                end
                ptr_m = (w + 1) % N;
            end
        end
        for (int c = 0; c < N; c++) begin
            if (consumer_read_ready[c] && !p_crr[c]) begin
                chk("rd_owner", 64'(c), 64'(cur));
                chk("rd_is_read", 64'(cur_rd), 1);
                for (int k = 0; k < RN; k++) exp_rd[c][k*DB +: DB] = mem_m[8'(int'(cur_addr) + k)];
                last_lat = cyc - raise_cyc[c];
                rv[c] = 1'b0; rd_act[c] = 0; void'(rq_a[c].pop_front());
            end
            if (consumer_write_ready[c] && !p_cwr[c]) begin
                chk("wr_owner", 64'(c), 64'(cur));
                chk("wr_is_write", 64'(cur_rd), 0);
                mem_m[cur_addr] = cur_data;
                wv[c] = 1'b0; wr_act[c] = 0;
                void'(wq_a[c].pop_front()); void'(wq_d[c].pop_front());
            end
            chk("rd_slot", 64'(consumer_read_data[c*RW +: RW]), 64'(exp_rd[c]));
        end
        p_mrv = mem_read_valid; p_mwv = mem_write_valid; p_mrr = mrr; p_mwr = mwr;
        p_crr = consumer_read_ready; p_cwr = consumer_write_ready;
        for (int c = 0; c < N; c++) begin
            if (!rd_act[c] && rq_a[c].size() > 0 && !consumer_read_ready[c]) begin
                rv[c] = 1'b1; raddr[c*AB +: AB] = rq_a[c][0]; rd_act[c] = 1; raise_cyc[c] = cyc;
            end
            if (!wr_act[c] && wq_a[c].size() > 0 && !consumer_write_ready[c]) begin
                wv[c] = 1'b1; waddr[c*AB +: AB] = wq_a[c][0]; wdata[c*DB +: DB] = wq_d[c][0];
                wr_act[c] = 1;
            end
        end
    endtask

    function automatic bit quiet();
        for (int c = 0; c < N; c++)
            if (rq_a[c].size() || wq_a[c].size() || rd_act[c] || wr_act[c]) return 0;
        return !(mem_read_valid || mem_write_valid || mrr || mwr ||
                 |consumer_read_ready || |consumer_write_ready);
    endfunction

    task automatic run_idle(input int budget);
        bit idle = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            idle = quiet();
            if (idle) break;
        end
        chk("drain", 64'(idle), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit");
    end

    initial begin
        cyc = 0; last_lat = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // All four read at once from rr_ptr 0: served 0,1,2,3.
        for (int c = 0; c < N; c++) rq_a[c].push_back(8'(c * 4));
        gseq.delete();
        run_idle(200);
        chk("t2_count", 64'(gseq.size()), 4);
        for (int i = 0; i < 4; i++) chk("t2_order", 64'(gseq[i]), 64'(i));
        chk("t2_slot3", 64'(consumer_read_data[3*RW +: RW]), 64'h100F0E0D);

        // Single read: minimum three-edge latency and word ordering.
        rq_a[0].push_back(8'h00);
        run_idle(100);
        chk("t1_latency", 64'(last_lat), 3);
        chk("t1_data", 64'(consumer_read_data[0 +: RW]), 64'h04030201);

        // Move the pointer to 2, then a write races two reads.
        rq_a[1].push_back(8'h40);
        run_idle(100);
        wq_a[2].push_back(8'd5); wq_d[2].push_back(8'd10);
        rq_a[0].push_back(8'h10);
        rq_a[3].push_back(8'h30);
        gseq.delete();
        run_idle(200);
        chk("t3_count", 64'(gseq.size()), 3);
        chk("t3_first", 64'(gseq[0]), 2);
        chk("t3_second", 64'(gseq[1]), 3);
        chk("t3_third", 64'(gseq[2]), 0);
        chk("t3_mem5", 64'(phys[5]), 10);

        // Continuous requesters alternate without starvation.
        for (int i = 0; i < 4; i++) rq_a[1].push_back(8'(8'h50 + i * 4));
        for (int i = 0; i < 3; i++) rq_a[0].push_back(8'(8'h60 + i * 4));
        gseq.delete();
        run_idle(400);
        chk("t4_count", 64'(gseq.size()), 7);
        for (int i = 0; i < 7; i++) chk("t4_alt", 64'(gseq[i]), (i % 2 == 0) ? 1 : 0);

        // Memory ready lingers after valid drops.
        hold_extra = 2;
        rq_a[0].push_back(8'h70);
        rq_a[2].push_back(8'h74);
        run_idle(200);
        hold_extra = 0;

        // Same consumer reads and writes together: read goes first.
        rq_a[1].push_back(8'h05);
        wq_a[1].push_back(8'h06); wq_d[1].push_back(8'hA5);
        gseq.delete();
        run_idle(200);
        chk("both_count", 64'(gseq.size()), 2);

        // Randomized traffic with varying memory latency and ready hold.
        for (int r = 0; r < 6; r++) begin
            mem_lat = int'($urandom_range(0, 2));
            hold_extra = int'($urandom_range(0, 1));
            for (int j = 0; j < 8; j++) begin
                int c;
                c = int'($urandom_range(0, N - 1));
                if ($urandom_range(0, 1) == 0) rq_a[c].push_back(8'($urandom));
                else begin
                    wq_a[c].push_back(8'($urandom));
                    wq_d[c].push_back(8'($urandom));
                end
            end
            run_idle(2000);
        end
        hold_extra = 0;

        // Asynchronous reset while waiting on memory.
        mem_lat = 3;
        rq_a[0].push_back(8'h20);
        step();
        step();
        chk("t6_in_wait", 64'(mem_read_valid), 1);
        #2 reset = 1'b1;
        #1 check_outputs_zero("async_reset");
        @(negedge clk);
        model_reset();
        mem_lat = 0;
        reset = 1'b0;
        rq_a[3].push_back(8'h08);
        gseq.delete();
        run_idle(100);
        chk("t6_count", 64'(gseq.size()), 1);
        chk("t6_first", 64'(gseq[0]), 3);
        chk("t6_slot3", 64'(consumer_read_data[3*RW +: RW]), 64'h0C0B0A09);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
